// File: rtl/inst_loader.sv
// inst_loader: debug-port writer for the instruction cache.
// Packs a little-endian byte stream into words and writes them through cache port B.
// It then reads the same region back and compares a 32-bit additive checksum.
// busy doubles as the CPU hold request while a load or verify is running.
//
// Byte stream handshake: a byte transfers on a rising clk edge where s_valid && s_ready.
// s_ready is registered and is high only in RECV. The source must hold s_data stable
// with s_valid high until the byte transfers, and must not withdraw a byte it has offered.
module inst_loader #(
  parameter int CNT_W     = 13,
  parameter int MEM_WORDS = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [29:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             web,
  output logic [29:0]      addrb,
  output logic [31:0]      dinb,
  input  logic [31:0]      doutb,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       dbg_state
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RECV   = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_VFLUSH = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [29:0]      base_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] idx;        // write index in WRITE, next read index in VERIFY
  logic [CNT_W-1:0] idx_next;
  logic [1:0]       byte_idx;
  logic [23:0]      word_lo;    // bytes 0..2 of the word being assembled
  logic [31:0]      sum_w;
  logic [31:0]      sum_r;
  logic [31:0]      sum_r_final;
  logic             rd_pend;    // doutb holds data for an address issued last cycle
  logic             accept;
  logic [30:0]      end_addr;
  logic             range_bad;
  logic [29:0]      cur_addr;

  assign dbg_state   = state;
  assign accept      = s_valid & s_ready;
  assign idx_next    = idx + CNT_W'(1);
  assign cur_addr    = base_q + 30'(idx);
  assign sum_r_final = sum_r + doutb;
  // The high-bit test keeps base below MEM_WORDS, so the wide sum cannot overflow.
  assign end_addr    = 31'(base_addr) + 31'(word_count);
  assign range_bad   = (base_addr[29:AW] != '0) || (end_addr > 31'(MEM_WORDS));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0 || range_bad) next_state = S_DONE;
          else                               next_state = S_RECV;
        end
      end
      S_RECV:   if (accept && byte_idx == 2'd3) next_state = S_WRITE;
      S_WRITE:  next_state = (idx_next == count_q) ? S_VERIFY : S_RECV;
      S_VERIFY: if (idx == count_q) next_state = S_VFLUSH;
      S_VFLUSH: next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      count_q  <= '0;
      idx      <= '0;
      byte_idx <= '0;
      word_lo  <= '0;
      sum_w    <= '0;
      sum_r    <= '0;
      rd_pend  <= 1'b0;
      s_ready  <= 1'b0;
      web      <= 1'b0;
      addrb    <= '0;
      dinb     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      web     <= 1'b0;
      s_ready <= (next_state == S_RECV);
      busy    <= (next_state inside {S_RECV, S_WRITE, S_VERIFY, S_VFLUSH});
      rd_pend <= (state == S_VERIFY);
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= word_count;
            idx      <= '0;
            byte_idx <= '0;
            sum_w    <= '0;
            sum_r    <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            if (word_count == '0) begin
              done <= 1'b1;
            end else if (range_bad) begin
              done  <= 1'b1;
              error <= 1'b1;
            end
          end
        end
        S_RECV: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              web   <= 1'b1;
              addrb <= cur_addr;
              dinb  <= {s_data, word_lo};
            end else begin
              word_lo[{byte_idx, 3'b000} +: 8] <= s_data;
            end
          end
        end
        S_WRITE: begin
          sum_w <= sum_w + dinb;
          if (idx_next == count_q) begin
            // First read address goes out on the first VERIFY cycle.
            idx   <= CNT_W'(1);
            addrb <= base_q;
          end else begin
            idx <= idx_next;
          end
        end
        S_VERIFY: begin
          if (rd_pend) sum_r <= sum_r + doutb;
          if (idx != count_q) begin
            addrb <= cur_addr;
            idx   <= idx_next;
          end
        end
        S_VFLUSH: begin
          sum_r <= sum_r_final;
          done  <= 1'b1;
          error <= (sum_r_final != sum_w);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Testbench for inst_loader: byte-stream driver, cache port-B memory model,
// and a scoreboard monitor fed by a high-level load model.
module tb_inst_loader;

  localparam int CNT_W = 13;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [29:0]      base_addr = '0;
  logic [CNT_W-1:0] word_count = '0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = '0;
  logic             s_ready;
  logic             web;
  logic [29:0]      addrb;
  logic [31:0]      dinb;
  logic [31:0]      doutb;
  logic             busy;
  logic             done;
  logic             error;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  inst_loader #(.CNT_W(CNT_W), .MEM_WORDS(4096)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .web        (web),
    .addrb      (addrb),
    .dinb       (dinb),
    .doutb      (doutb),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- cache port B model ----------------
  logic [31:0] mem [0:4095];
  bit          corrupt_en = 1'b0;
  int          corrupt_addr = 0;

  always @(posedge clk) begin
    if (web) mem[addrb[11:0]] <= dinb;
    if (corrupt_en && addrb == 30'(corrupt_addr)) doutb <= mem[addrb[11:0]] ^ 32'h1;
    else                                          doutb <= mem[addrb[11:0]];
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [61:0] exp_wr_q[$];   // {addr, data} of each expected write
  logic [0:0]  exp_err_q[$];  // expected error flag per load
  int          exp_lat_q[$];  // expected last-write-to-done cycles per load
  int          exp_acc = 0;   // bytes the DUT should have accepted since reset
  bit          imm_load = 1'b0;
  logic [7:0]  byte_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  int acc_cnt;
  bit after4;
  bit done_prev;
  int last_web_cyc;

  always @(negedge clk) begin
    if (rst) begin
      acc_cnt   = 0;
      after4    = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (web) begin
        if (exp_wr_q.size() == 0) fail("unexpected_write", {2'b0, addrb, dinb}, 64'd0);
        else check("write", {2'b0, addrb, dinb}, {2'b0, exp_wr_q.pop_front()});
        last_web_cyc = cyc;
      end
      if (after4) check("s_ready_after_4th_byte", 64'(s_ready), 64'd0);
      after4 = 1'b0;
      if (s_valid && s_ready) begin
        acc_cnt++;
        after4 = (acc_cnt % 4 == 0);
      end
      if (done && !done_prev && !imm_load) begin
        if (exp_err_q.size() == 0) begin
          fail("spurious_done", 64'(done), 64'd0);
        end else begin
          check("error_flag", 64'(error), 64'(exp_err_q.pop_front()));
          check("done_latency", 64'(cyc - last_web_cyc), 64'(exp_lat_q.pop_front()));
          check("bytes_accepted", 64'(acc_cnt), 64'(exp_acc));
          check("writes_outstanding", 64'(exp_wr_q.size()), 64'd0);
        end
      end
      done_prev = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input int base, input int count);
    start      = 1'b1;
    base_addr  = 30'(base);
    word_count = CNT_W'(count);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 one idle cycle before every byte, 2 random 0..2 idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit hs;
    int idle;
    hs   = 1'b0;
    idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
    s_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    for (int n = 0; n < 100 && !hs; n++) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
    end
    if (!hs) fail("byte_accept_timeout", 64'(hs), 64'd1);
    s_valid = 1'b0;
  endtask

  // Reference: a load either finishes at once (empty, or outside the cache) or
  // writes word i = bytes 4i..4i+3 little-endian at base+i, then reports whether
  // the read-back differs from what was written.
  task automatic do_load(input int base, input int count, input int gap, input bit poke);
    bit          imm;
    bit          corr;
    logic [31:0] w;
    int          waited;
    imm = (count == 0) || (base >= 4096) || (base + count > 4096);
    while (byte_q.size() < 4 * count) byte_q.push_back(8'($urandom_range(0, 255)));
    if (imm) begin
      imm_load = 1'b1;
      pulse_start(base, count);
      check("imm_done", 64'(done), 64'd1);
      check("imm_error", 64'(error), 64'(count != 0));
      check("imm_busy", 64'(busy), 64'd0);
      check("imm_s_ready", 64'(s_ready), 64'd0);
      @(posedge clk); #1;
      imm_load = 1'b0;
      byte_q.delete();
      return;
    end
    for (int i = 0; i < count; i++) begin
      w = {byte_q[4*i+3], byte_q[4*i+2], byte_q[4*i+1], byte_q[4*i]};
      exp_wr_q.push_back({30'(base + i), w});
    end
    corr = corrupt_en && corrupt_addr >= base && corrupt_addr < base + count;
    exp_err_q.push_back(corr);
    exp_lat_q.push_back(count + 2);
    exp_acc += 4 * count;
    pulse_start(base, count);
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_cleared_on_start", 64'(done), 64'd0);
    for (int k = 0; k < 4 * count; k++) begin
      send_byte(byte_q[k], gap);
      if (poke && k == 0) begin
        pulse_start(7, 1);
        check("busy_after_ignored_start", 64'(busy), 64'd1);
      end
    end
    byte_q.delete();
    waited = 0;
    while (exp_err_q.size() != 0 && waited < 3000) begin
      @(posedge clk);
      waited++;
    end
    #1;
    if (exp_err_q.size() != 0) begin
      fail("done_timeout", 64'(waited), 64'(count + 2));
      exp_err_q.delete();
      exp_lat_q.delete();
      exp_wr_q.delete();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] rb [6];
    int base;
    int count;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 64'(dbg_state), 64'd0);
    check("reset_outputs", {31'd0, s_ready, web, busy, done, error},  64'd0);
    check("reset_addr_data", {2'b0, addrb, dinb}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed load from the instruction image.
    byte_q = '{8'h13, 8'h47, 8'h40, 8'h00, 8'h93, 8'h46, 8'h40, 8'h00};
    do_load(0, 2, 0, 1'b0);
    check("mem0_word", 64'(mem[0]), 64'h0040_4713);
    check("mem1_word", 64'(mem[1]), 64'h0040_4693);
    check("good_load_error", 64'(error), 64'd0);

    // Same image with s_valid toggling every other cycle.
    byte_q = '{8'h13, 8'h47, 8'h40, 8'h00, 8'h93, 8'h46, 8'h40, 8'h00};
    do_load(0, 2, 1, 1'b0);

    // Out of range, high address bits set, and empty loads.
    do_load(32'hFFF, 2, 0, 1'b0);
    do_load(32'h1000, 1, 0, 1'b0);
    do_load(5, 0, 0, 1'b0);

    // Corrupted read-back at word address 1.
    corrupt_en   = 1'b1;
    corrupt_addr = 1;
    do_load(0, 3, 2, 1'b0);
    corrupt_en = 1'b0;

    // Reset two bytes into the second word, then a fresh load.
    for (int k = 0; k < 6; k++) rb[k] = 8'($urandom_range(0, 255));
    exp_wr_q.push_back({30'd100, rb[3], rb[2], rb[1], rb[0]});
    pulse_start(100, 3);
    for (int k = 0; k < 6; k++) send_byte(rb[k], 0);
    rst = 1'b1;
    #1;
    check("midload_reset_state", 64'(dbg_state), 64'd0);
    check("midload_reset_outputs", {31'd0, s_ready, web, busy, done, error}, 64'd0);
    check("midload_reset_addr_data", {2'b0, addrb, dinb}, 64'd0);
    check("midload_first_word_written", 64'(exp_wr_q.size()), 64'd0);
    exp_err_q.delete();
    exp_lat_q.delete();
    exp_wr_q.delete();
    exp_acc = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_load(200, 2, 0, 1'b0);

    // Start pulsed while busy must not disturb the running load.
    do_load(300, 2, 2, 1'b1);

    // Randomized loads, roughly a quarter of them out of range.
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        base  = 4090 + int'($urandom_range(0, 5));
        count = 7 + int'($urandom_range(0, 2));
      end else begin
        base  = int'($urandom_range(0, 4090));
        count = int'($urandom_range(1, 5));
      end
      do_load(base, count, int'($urandom_range(0, 2)), 1'b0);
    end

    // Load ending exactly at the top word.
    do_load(4094, 2, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #900000;
    fail("global_timeout", 64'(cyc), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
